// File: rtl/iob_cache_be_arbiter.sv
// Two-master back-end arbiter: shares one native memory port between two cache back-ends.
// Define IOB_CACHE_BE_ARB_RR_EN for round-robin arbitration; otherwise master 0 has fixed priority.
module iob_cache_be_arbiter #(
  parameter int BE_ADDR_W = 24,
  parameter int BE_DATA_W = 32,
  parameter int LINE2BE_W = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,

  input  logic                   m0_req,
  input  logic [BE_ADDR_W-1:0]   m0_addr,
  input  logic [BE_DATA_W-1:0]   m0_wdata,
  input  logic [BE_DATA_W/8-1:0] m0_wstrb,
  output logic [BE_DATA_W-1:0]   m0_rdata,
  output logic                   m0_ack,

  input  logic                   m1_req,
  input  logic [BE_ADDR_W-1:0]   m1_addr,
  input  logic [BE_DATA_W-1:0]   m1_wdata,
  input  logic [BE_DATA_W/8-1:0] m1_wstrb,
  output logic [BE_DATA_W-1:0]   m1_rdata,
  output logic                   m1_ack,

  output logic                   be_req,
  output logic [BE_ADDR_W-1:0]   be_addr,
  output logic [BE_DATA_W-1:0]   be_wdata,
  output logic [BE_DATA_W/8-1:0] be_wstrb,
  input  logic [BE_DATA_W-1:0]   be_rdata,
  input  logic                   be_ack
);

  localparam int STRB_W = BE_DATA_W / 8;
  localparam int CNT_W  = (LINE2BE_W > 0) ? LINE2BE_W : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // Counter value loaded for a line-fill read: the last beat is the one seen at zero.
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'((1 << LINE2BE_W) - 1);

  logic [0:0]       state_reg, state_next;
  logic             grant_reg, grant_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic             any_req;
  logic             winner;
  logic [STRB_W-1:0] winner_wstrb;
  logic             winner_is_read;
  logic             busy;
  logic             gnt_req;
  logic             beat;
  logic [1:0]       ack_vec;

  assign any_req = m0_req | m1_req;

`ifdef IOB_CACHE_BE_ARB_RR_EN
  logic last_reg, last_next;

  // On a tie the master that did not win last time is served.
  assign winner = (m0_req & m1_req) ? ~last_reg : ~m0_req;

  always_comb begin
    last_next = last_reg;
    if (state_reg == IDLE && any_req) begin
      last_next = winner;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_reg <= 1'b1;
    end else begin
      last_reg <= last_next;
    end
  end
`else
  assign winner = ~m0_req;
`endif

  assign winner_wstrb   = winner ? m1_wstrb : m0_wstrb;
  assign winner_is_read = (winner_wstrb == '0);

  assign busy    = (state_reg == BUSY);
  assign gnt_req = grant_reg ? m1_req : m0_req;

  // be_req is gated by reset so a burst in flight is silenced immediately.
  assign be_req   = busy & gnt_req & ~rst_i;
  assign be_addr  = busy ? (grant_reg ? m1_addr  : m0_addr)  : '0;
  assign be_wdata = busy ? (grant_reg ? m1_wdata : m0_wdata) : '0;
  assign be_wstrb = busy ? (grant_reg ? m1_wstrb : m0_wstrb) : '0;

  // Acks arriving with be_req low are stray and never reach a master.
  assign beat = be_ack & be_req;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_vec[gi] = beat & (grant_reg == 1'(gi));
    end
  endgenerate

  assign m0_ack   = ack_vec[0];
  assign m1_ack   = ack_vec[1];
  assign m0_rdata = be_rdata;
  assign m1_rdata = be_rdata;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = BUSY;
          grant_next = winner;
          cnt_next   = winner_is_read ? READ_LAST : '0;
        end
      end
      default: begin
        // Grant is held until every beat is acked, even if the master drops req.
        if (beat) begin
          if (cnt_reg == '0) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      grant_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: doc/iob_cache_be_arbiter.md
IOB_CACHE_BE_ARBITER -- requirements
Module: iob_cache_be_arbiter

Interface
REQ-001 SHALL have parameter BE_ADDR_W, default 24, back-end byte address width.
REQ-002 SHALL have parameter BE_DATA_W, default 32, back-end data width; strobe width is BE_DATA_W/8.
REQ-003 SHALL have parameter LINE2BE_W, default 2, log2 of beats per line-fill read burst.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_i input 1 is the system clock; rst_i input 1 is the reset.
REQ-005 SHALL have port m0_req, input, 1 bit: master 0 request.
REQ-006 SHALL have port m0_addr, input, BE_ADDR_W bits: master 0 address.
REQ-007 SHALL have port m0_wdata, input, BE_DATA_W bits: master 0 write data.
REQ-008 SHALL have port m0_wstrb, input, BE_DATA_W/8 bits: master 0 write strobe; all zeros means read.
REQ-009 SHALL have port m0_rdata, output, BE_DATA_W bits: master 0 read data.
REQ-010 SHALL have port m0_ack, output, 1 bit: master 0 acknowledge.
REQ-011 SHALL have ports m1_req, m1_addr, m1_wdata, m1_wstrb, m1_rdata and m1_ack, identical to the m0_* ports, for master 1.
REQ-012 SHALL have ports be_req (output, 1), be_addr (output, BE_ADDR_W), be_wdata (output, BE_DATA_W), be_wstrb (output, BE_DATA_W/8), be_rdata (input, BE_DATA_W) and be_ack (input, 1), forming the shared memory-side native port.

Function
REQ-013 SHALL arbitrate two cache back-ends (e.g. I- and D-cache) onto one memory port with FSM states IDLE and BUSY.
REQ-014 In IDLE with at least one mN_req high, SHALL register the winner as grant, sample the transaction type (read if the winner's wstrb==0), and enter BUSY the next cycle.
REQ-015 Request-to-be_req latency SHALL be exactly 1 cycle from IDLE.
REQ-016 In BUSY, be_req SHALL equal the granted master's req, and be_addr/be_wdata/be_wstrb SHALL be combinationally muxed from the granted master.
REQ-017 Outside BUSY, be_req and be_wstrb SHALL be 0, and be_addr and be_wdata SHALL be 0.
REQ-018 mN_ack SHALL equal be_ack & be_req & (grant==N); the non-granted master's ack SHALL be 0.
REQ-019 m0_rdata and m1_rdata SHALL both equal be_rdata unconditionally.
REQ-020 A beat counter SHALL load 2**LINE2BE_W-1 on a read grant and 0 on a write grant, and SHALL decrement on each counted ack (be_ack & be_req).
REQ-021 A counted ack with the counter at 0 SHALL return the FSM to IDLE, giving a one-cycle bubble (be_req=0) before the next grant.
REQ-022 A be_ack received while be_req=0 SHALL be ignored (not counted, not forwarded).
REQ-023 If the granted master drops req mid-burst, the grant SHALL be held in BUSY until the remaining beats are acked, with no timeout.
REQ-024 A master's address may change between beats of a burst; the arbiter SHALL pass each beat's address through unmodified.

Reset
REQ-025 rst_i high at a rising clk_i edge SHALL force IDLE, counter=0, last-grant pointer=1, and grant=0, including when asserted mid-burst; a burst interrupted by reset SHALL be abandoned.
REQ-026 While in reset and the cycle after, be_req, m0_ack and m1_ack SHALL be 0.

Configuration
REQ-027 Macro IOB_CACHE_BE_ARB_RR_EN defined SHALL enable round-robin arbitration: on simultaneous requests in IDLE, grant SHALL go to the master not granted last, and the pointer SHALL update at each grant; after reset, master 0 SHALL win first.
REQ-028 Macro IOB_CACHE_BE_ARB_RR_EN undefined SHALL select fixed priority (master 0 always wins simultaneous requests) and SHALL remove the pointer register.

Verification
REQ-029 Single read: m0 read at 0x100, LINE2BE_W=2, be_ack every cycle -> be_req rises 1 cycle after m0_req, 4 m0_acks, then IDLE; m1_ack stays 0.
REQ-030 Single write: m1 write, wstrb=0xF, data 0xDEADBEEF, ack after 3 cycles -> be_wdata=0xDEADBEEF, be_wstrb=0xF, one m1_ack, then IDLE next cycle.
REQ-031 Contention with RR enabled: m0 and m1 both requesting reads continuously -> grants alternate m0,m1,m0,m1; each burst is 4 beats separated by a 1-cycle bubble.
REQ-032 Contention with RR disabled: same stimulus -> m0 granted every burst; m1 is never granted while m0_req stays high.
REQ-033 Reset mid-burst: rst_i pulsed after the 2nd of 4 acks -> next cycle be_req=0 and IDLE; a new m1 request is granted 1 cycle after rst_i falls.
REQ-034 Stray ack: be_ack=1 while in IDLE -> no mN_ack and no state change.
